// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg
// Shared definitions for the MIPS execute stage:
//   - ALU operation codes carried on alu_ctl
//   - result-mux select codes carried on total_alu_sel
//   - multiplier FSM state encoding (2 bits)
package ex_stage_pkg;

  localparam int XLEN = 32;

  // ALU operation codes. Codes 3'b100 and 3'b101 are unassigned and yield 0.
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // EX result mux select.
  typedef enum logic [1:0] {
    SEL_ALU   = 2'b00,
    SEL_SHIFT = 2'b01,
    SEL_HI    = 2'b10,
    SEL_LO    = 2'b11
  } res_sel_e;

  // Sequential multiplier states.
  typedef enum logic [1:0] {
    MS_IDLE = 2'b00,
    MS_BUSY = 2'b01,
    MS_DONE = 2'b10
  } mult_state_e;

endpackage

// File: rtl/ex_stage_multu_seq.sv
// multu_seq
// 32-cycle shift-add unsigned multiplier owning the HI/LO registers.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_start          multu present in EX; sampled only in IDLE
//   i_mcand          multiplicand (rd1), latched at start
//   i_mplier         multiplier (rd2), loaded into P[31:0] at start
//   o_hi, o_lo       HI/LO registers, written on the DONE exit edge
//   o_busy           FSM not IDLE
//   o_state          current FSM state (DONE is used by the stall logic)
// Handshake: i_start is a level request seen only in IDLE; once BUSY the
// multiply always runs to completion, so dropping i_start (flush) does not
// abort it. There is no ready back-pressure; the caller stalls on state.
module multu_seq
  import ex_stage_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [31:0]       i_mcand,
  input  logic [31:0]       i_mplier,
  output logic [31:0]       o_hi,
  output logic [31:0]       o_lo,
  output logic              o_busy,
  output mult_state_e       o_state
);

  mult_state_e r_state;
  mult_state_e w_state_nxt;
  logic [63:0] r_p;
  logic [31:0] r_mcand;
  logic [4:0]  r_count;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic [32:0] w_sum;
  logic [63:0] w_p_step;

  // One shift-add step: add the multiplicand into the upper half with a
  // 33-bit carry, then shift the whole product right by one.
  assign w_sum    = {1'b0, r_p[63:32]} + {1'b0, r_mcand};
  assign w_p_step = r_p[0] ? {w_sum, r_p[31:1]} : {1'b0, r_p[63:1]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= MS_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MS_IDLE: if (i_start) w_state_nxt = MS_BUSY;
      MS_BUSY: if (r_count == 5'd31) w_state_nxt = MS_DONE;
      MS_DONE: w_state_nxt = MS_IDLE;
      default: w_state_nxt = MS_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_p     <= '0;
      r_mcand <= '0;
      r_count <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        MS_IDLE: begin
          if (i_start) begin
            r_mcand <= i_mcand;
            r_p     <= {32'b0, i_mplier};
            r_count <= '0;
          end
        end
        MS_BUSY: begin
          r_p     <= w_p_step;
          r_count <= r_count + 5'd1;
        end
        MS_DONE: begin
          r_hi <= r_p[63:32];
          r_lo <= r_p[31:0];
        end
        default: ;
      endcase
    end
  end

  assign o_hi    = r_hi;
  assign o_lo    = r_lo;
  assign o_busy  = (r_state != MS_IDLE);
  assign o_state = r_state;

endmodule

// File: rtl/ex_stage.sv
// ex_stage
// Execute stage of the five-stage MIPS pipeline: ALU, logical right shifter,
// result mux and the multu stall, plus the sequential multiplier (multu_seq).
// Optional feature macro: ALU_OVF_EN adds the ovf port (signed add/sub
// overflow flag).
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   rd1, rd2        register operands (rd2 is also the multiplier)
//   extend_immed    sign-extended immediate; [10:6] is shamt
//   ALUSrc          1 selects extend_immed as ALU operand B
//   alu_ctl         ALU operation
//   multuOp         multu in EX
//   total_alu_sel   result select: ALU / shifter / HI / LO
//   result, zero    EX result and ALU-zero flag (combinational)
//   stall           freezes IF, ID and ID/EX while a multu is in flight
//   mult_busy       multiplier not IDLE
//   hi, lo          HI/LO registers
//   ovf             (ALU_OVF_EN only) signed add/sub overflow
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rd1,
  input  logic [31:0] rd2,
  input  logic [31:0] extend_immed,
  input  logic        ALUSrc,
  input  logic [2:0]  alu_ctl,
  input  logic        multuOp,
  input  logic [1:0]  total_alu_sel,
  output logic [31:0] result,
  output logic        zero,
  output logic        stall,
  output logic        mult_busy,
  output logic [31:0] hi,
  output logic [31:0] lo
`ifdef ALU_OVF_EN
  ,
  output logic        ovf
`endif
);

  logic [31:0] w_op_b;
  logic [31:0] w_sum;
  logic [31:0] w_diff;
  logic [31:0] w_alu;
  logic [31:0] w_shift;
  logic [4:0]  w_shamt;
  logic        w_busy;
  mult_state_e w_mult_state;

  assign w_op_b  = ALUSrc ? extend_immed : rd2;
  assign w_sum   = rd1 + w_op_b;
  assign w_diff  = rd1 - w_op_b;
  assign w_shamt = extend_immed[10:6];
  assign w_shift = rd2 >> w_shamt;

  always_comb begin
    w_alu = '0;
    case (alu_ctl)
      ALU_AND: w_alu = rd1 & w_op_b;
      ALU_OR:  w_alu = rd1 | w_op_b;
      ALU_ADD: w_alu = w_sum;
      ALU_XOR: w_alu = rd1 ^ w_op_b;
      ALU_SUB: w_alu = w_diff;
      ALU_SLT: w_alu = {31'b0, ($signed(rd1) < $signed(w_op_b))};
      default: w_alu = '0;
    endcase
  end

  assign zero = (w_alu == 32'd0);

  always_comb begin
    result = w_alu;
    case (total_alu_sel)
      SEL_ALU:   result = w_alu;
      SEL_SHIFT: result = w_shift;
      SEL_HI:    result = hi;
      SEL_LO:    result = lo;
      default:   result = w_alu;
    endcase
  end

`ifdef ALU_OVF_EN
  always_comb begin
    ovf = 1'b0;
    if (alu_ctl == ALU_ADD)
      ovf = (rd1[31] == w_op_b[31]) && (w_sum[31] != rd1[31]);
    else if (alu_ctl == ALU_SUB)
      ovf = (rd1[31] != w_op_b[31]) && (w_diff[31] != rd1[31]);
  end
`endif

  multu_seq u_multu_seq (
    .i_clk    (clk),
    .i_rst_n  (rst),
    .i_start  (multuOp),
    .i_mcand  (rd1),
    .i_mplier (rd2),
    .o_hi     (hi),
    .o_lo     (lo),
    .o_busy   (w_busy),
    .o_state  (w_mult_state)
  );

  // The DONE cycle releases the stall so the multu leaves ID/EX on that edge;
  // a multu seen afterwards is a new instruction and starts from IDLE.
  assign stall     = multuOp && (w_mult_state != MS_DONE);
  assign mult_busy = w_busy;

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rd1, rd2, extend_immed;
  logic        ALUSrc;
  logic [2:0]  alu_ctl;
  logic        multuOp;
  logic [1:0]  total_alu_sel;
  logic [31:0] result, hi, lo;
  logic        zero, stall, mult_busy;
`ifdef ALU_OVF_EN
  logic        ovf;
`endif

  always #5 clk = ~clk;

  ex_stage dut (
    .clk           (clk),
    .rst           (rst),
    .rd1           (rd1),
    .rd2           (rd2),
    .extend_immed  (extend_immed),
    .ALUSrc        (ALUSrc),
    .alu_ctl       (alu_ctl),
    .multuOp       (multuOp),
    .total_alu_sel (total_alu_sel),
    .result        (result),
    .zero          (zero),
    .stall         (stall),
    .mult_busy     (mult_busy),
    .hi            (hi),
    .lo            (lo)
`ifdef ALU_OVF_EN
    ,
    .ovf           (ovf)
`endif
  );

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];
  logic [31:0] prev_hi = 32'd0;
  logic [31:0] prev_lo = 32'd0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic alu_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic src, input logic [2:0] ctl,
                         input logic [1:0] sel, input logic [31:0] exp_res,
                         input logic exp_zero, input logic exp_ovf);
    @(negedge clk);
    rd1 = a; rd2 = b; extend_immed = imm; ALUSrc = src;
    alu_ctl = ctl; total_alu_sel = sel; multuOp = 1'b0;
    #1;
    check({tag, " result"}, {32'b0, result}, {32'b0, exp_res});
    check({tag, " zero"}, {63'b0, zero}, {63'b0, exp_zero});
`ifdef ALU_OVF_EN
    check({tag, " ovf"}, {63'b0, ovf}, {63'b0, exp_ovf});
`else
    if (exp_ovf === 1'bx) n_cmp = n_cmp;
`endif
  endtask

  // Called just after a negedge: that cycle is C0. Returns during C34 with
  // multuOp low, leaving time in the cycle for a back-to-back issue.
  task automatic do_multu(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp_prod, input int drop_at);
    logic [63:0] e;
    logic        exp_stall;
    rd1 = a; rd2 = b; multuOp = 1'b1; total_alu_sel = 2'b00;
    alu_ctl = 3'b000; ALUSrc = 1'b0;
    exp_q.push_back(exp_prod);
    for (int c = 0; c <= 33; c++) begin
      #1;
      exp_stall = (c < drop_at) && (c <= 32);
      check($sformatf("%s stall c%0d", tag, c), {63'b0, stall}, {63'b0, exp_stall});
      check($sformatf("%s busy c%0d", tag, c), {63'b0, mult_busy}, {63'b0, (c >= 1)});
      if (c == 33)
        check($sformatf("%s hilo held c33", tag), {hi, lo}, {prev_hi, prev_lo});
      @(negedge clk);
      if (c + 1 == drop_at) multuOp = 1'b0;
    end
    multuOp = 1'b0;
    #1;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = 64'hDEAD_BEEF_DEAD_BEEF;
    check({tag, " hi"}, {32'b0, hi}, {32'b0, e[63:32]});
    check({tag, " lo"}, {32'b0, lo}, {32'b0, e[31:0]});
    check({tag, " busy c34"}, {63'b0, mult_busy}, 64'd0);
    total_alu_sel = 2'b10;
    #1 check({tag, " mfhi"}, {32'b0, result}, {32'b0, e[63:32]});
    total_alu_sel = 2'b11;
    #1 check({tag, " mflo"}, {32'b0, result}, {32'b0, e[31:0]});
    total_alu_sel = 2'b00;
    prev_hi = e[63:32];
    prev_lo = e[31:0];
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rd1 = '0; rd2 = '0; extend_immed = '0; ALUSrc = 1'b0;
    alu_ctl = 3'b000; multuOp = 1'b0; total_alu_sel = 2'b00;
    rst = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
    #1;
    check("rst hi", {32'b0, hi}, 64'd0);
    check("rst lo", {32'b0, lo}, 64'd0);
    check("rst busy", {63'b0, mult_busy}, 64'd0);
    check("rst stall", {63'b0, stall}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // ALU / shifter directed vectors
    alu_vec("add ovf", 32'h7FFFFFFF, 32'h1, 32'h0, 1'b0, 3'b010, 2'b00, 32'h80000000, 1'b0, 1'b1);
    alu_vec("add wrap", 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 3'b010, 2'b00, 32'h0, 1'b1, 1'b0);
    alu_vec("sub eq", 32'd5, 32'd5, 32'h0, 1'b0, 3'b110, 2'b00, 32'h0, 1'b1, 1'b0);
    alu_vec("sub ovf", 32'h80000000, 32'h1, 32'h0, 1'b0, 3'b110, 2'b00, 32'h7FFFFFFF, 1'b0, 1'b1);
    alu_vec("slt lt", 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 3'b111, 2'b00, 32'h1, 1'b0, 1'b0);
    alu_vec("slt ge", 32'h1, 32'hFFFFFFFF, 32'h0, 1'b0, 3'b111, 2'b00, 32'h0, 1'b1, 1'b0);
    alu_vec("and imm", 32'h1234, 32'hFFFFFFFF, 32'hFFFFFFF0, 1'b1, 3'b000, 2'b00, 32'h1230, 1'b0, 1'b0);
    alu_vec("or", 32'h0000F0F0, 32'h00000F0F, 32'h0, 1'b0, 3'b001, 2'b00, 32'h0000FFFF, 1'b0, 1'b0);
    alu_vec("xor", 32'hFF00FF00, 32'h0FF00FF0, 32'h0, 1'b0, 3'b011, 2'b00, 32'hF0F0F0F0, 1'b0, 1'b0);
    alu_vec("op100", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b0, 3'b100, 2'b00, 32'h0, 1'b1, 1'b0);
    alu_vec("op101", 32'h12345678, 32'h1, 32'h0, 1'b0, 3'b101, 2'b00, 32'h0, 1'b1, 1'b0);
    alu_vec("srl", 32'h0, 32'h80000000, 32'h00000100, 1'b0, 3'b000, 2'b01, 32'h08000000, 1'b1, 1'b0);

    // multu max x max
    @(negedge clk);
    do_multu("mul ff", 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 99);

    // reset asserted mid-BUSY discards the partial product and clears HI/LO
    @(negedge clk);
    rd1 = 32'd5; rd2 = 32'd5; multuOp = 1'b1;
    repeat (15) @(negedge clk);
    multuOp = 1'b0;
    rst = 1'b0;
    #1;
    check("midrst busy", {63'b0, mult_busy}, 64'd0);
    check("midrst stall", {63'b0, stall}, 64'd0);
    check("midrst hi", {32'b0, hi}, 64'd0);
    check("midrst lo", {32'b0, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (k % 10 == 0) begin
        check($sformatf("post rst busy %0d", k), {63'b0, mult_busy}, 64'd0);
        check($sformatf("post rst hilo %0d", k), {hi, lo}, 64'd0);
      end
    end
    prev_hi = 32'd0;
    prev_lo = 32'd0;

    // zero multiplicand, then an immediately following multu
    @(negedge clk);
    do_multu("mul 0", 32'h0, 32'h12345678, 64'h0, 99);
    do_multu("mul 3x7", 32'd3, 32'd7, 64'd21, 99);

    // flush at C10: stall drops, multiply still completes
    @(negedge clk);
    do_multu("mul flush", 32'hFFFFFFFF, 32'd2, 64'h00000001_FFFFFFFE, 10);

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
